// File: rtl/sqrt_pkg.sv
// Shared constants and state encoding for the root check unit.
// Imported by the interface, the correction step and the top.
package sqrt_pkg;

  localparam int ROOT_W    = 8;
  localparam int X_W       = 2 * ROOT_W;
  localparam int MUL_ITERS = ROOT_W;
  localparam int CNT_W     = $clog2(MUL_ITERS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    CORR = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/sqrt_check_iter_if.sv
// Request/result bundle of sqrt_check_iter.
// slave: the checker; master: the block that feeds it.
interface sqrt_check_iter_if;
  import sqrt_pkg::*;

  logic              val_i;
  logic [X_W-1:0]    x_i;
  logic [ROOT_W-1:0] root_i;
  logic              rdy_o;
  logic              val_o;
  logic [ROOT_W-1:0] root_o;
  logic [X_W-1:0]    rem_o;
  logic [X_W-1:0]    square_o;
  logic              err_o;

  modport slave (
    input  val_i, x_i, root_i,
    output rdy_o, val_o, root_o,
    output rem_o, square_o, err_o
  );

  modport master (
    output val_i, x_i, root_i,
    input  rdy_o, val_o, root_o,
    input  rem_o, square_o, err_o
  );

endinterface

// File: rtl/sqrt_corr_step.sv
// One +/-1 root correction step (combinational).
// in: i_x radicand, i_r root, i_sq = i_r^2; out: o_root, o_rem, o_err.
module sqrt_corr_step
  import sqrt_pkg::*;
(
  input  logic [X_W-1:0]    i_x,
  input  logic [ROOT_W-1:0] i_r,
  input  logic [X_W-1:0]    i_sq,
  output logic [ROOT_W-1:0] o_root,
  output logic [X_W-1:0]    o_rem,
  output logic              o_err
);

  localparam logic [ROOT_W-1:0] ONE = 1;

  logic signed [17:0] w_d;
  logic signed [17:0] w_two_r;
  logic signed [17:0] w_dn_rem;
  logic signed [17:0] w_up_rem;
  logic signed [17:0] w_up_lim;

  assign w_d      = $signed({2'b00, i_x})
                  - $signed({2'b00, i_sq});
  assign w_two_r  = $signed({9'd0, i_r, 1'b0});
  assign w_dn_rem = w_d + w_two_r - 18'sd1;
  assign w_up_rem = w_d - w_two_r - 18'sd1;
  assign w_up_lim = w_two_r + 18'sd2;

  // d<0 and d>2r are disjoint since 2r >= 0
  always_comb begin
    o_root = i_r;
    o_rem  = w_d[X_W-1:0];
    o_err  = 1'b0;
    unique case (1'b1)
      (w_d < 18'sd0): begin
        o_root = i_r - ONE;
        o_rem  = w_dn_rem[X_W-1:0];
        o_err  = (w_dn_rem < 18'sd0);
      end
      (w_d > w_two_r): begin
        o_root = i_r + ONE;
        o_rem  = w_up_rem[X_W-1:0];
        o_err  = (w_up_rem > w_up_lim);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sqrt_check_iter.sv
// Squares an approximate root by shift-add, then corrects it by +/-1.
// clk, rst (async, active-high); bus: sqrt_check_iter_if.slave.
module sqrt_check_iter
  import sqrt_pkg::*;
(
  input logic              clk,
  input logic              rst,
  sqrt_check_iter_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_BIT =
    CNT_W'(MUL_ITERS - 1);

  state_t r_state;
  state_t w_next;

  logic [X_W-1:0]    r_x;
  logic [ROOT_W-1:0] r_r;
  logic [X_W-1:0]    r_acc;
  logic [CNT_W-1:0]  r_cnt;

  logic              r_val;
  logic [ROOT_W-1:0] r_root;
  logic [X_W-1:0]    r_rem;
  logic [X_W-1:0]    r_sq;
  logic              r_err;

  logic [X_W-1:0]    w_addend;
  logic [ROOT_W-1:0] w_root;
  logic [X_W-1:0]    w_rem;
  logic              w_err;

  assign w_addend = {{ROOT_W{1'b0}}, r_r} << r_cnt;

  sqrt_corr_step u_corr (
    .i_x    (r_x),
    .i_r    (r_r),
    .i_sq   (r_acc),
    .o_root (w_root),
    .o_rem  (w_rem),
    .o_err  (w_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (bus.val_i) w_next = MUL;
      MUL:  if (r_cnt == LAST_BIT) w_next = CORR;
      CORR: w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x    <= '0;
      r_r    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_val  <= 1'b0;
      r_root <= '0;
      r_rem  <= '0;
      r_sq   <= '0;
      r_err  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.val_i) begin
            r_x   <= bus.x_i;
            r_r   <= bus.root_i;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        MUL: begin
          if (r_r[r_cnt]) r_acc <= r_acc + w_addend;
          r_cnt <= r_cnt + 1'b1;
        end
        CORR: begin
          r_val  <= 1'b1;
          r_root <= w_root;
          r_rem  <= w_rem;
          r_sq   <= r_acc;
          r_err  <= w_err;
        end
        DONE: r_val <= 1'b0;
        default: r_val <= 1'b0;
      endcase
    end
  end

  assign bus.rdy_o    = (r_state == IDLE) && !rst;
  assign bus.val_o    = r_val;
  assign bus.root_o   = r_root;
  assign bus.rem_o    = r_rem;
  assign bus.square_o = r_sq;
  assign bus.err_o    = r_err;

endmodule

// File: tb/tb_sqrt_check_iter.sv
// Scoreboard bench for sqrt_check_iter.
// Directed cases, random ops, back-to-back requests, mid-op reset.
module tb_sqrt_check_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sqrt_check_iter_if bus ();

  sqrt_check_iter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int x;
    int root;
    int rem;
    int sq;
    int err;
    int cyc;
  } exp_t;

  exp_t q[$];
  int tests   = 0;
  int fails   = 0;
  int accepts = 0;
  int pulses  = 0;

  function automatic exp_t model(int x, int r);
    exp_t e;
    int d, rem, root, err;
    d = x - r * r;
    root = r; rem = d; err = 0;
    if (d < 0) begin
      root = r - 1;
      rem = d + 2 * r - 1;
      err = (rem < 0) ? 1 : 0;
    end else if (d > 2 * r) begin
      root = r + 1;
      rem = d - (2 * r + 1);
      err = (rem > 2 * (r + 1)) ? 1 : 0;
    end
    e.x = x; e.root = root;
    e.rem = rem & 32'hFFFF;
    e.sq = r * r; e.err = err;
    e.cyc = 0;
    return e;
  endfunction

  function automatic int isqrt(int x);
    int s = 0;
    while ((s + 1) * (s + 1) <= x) s++;
    return s;
  endfunction

  task automatic chk(string nm, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d",
               nm, act, req);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst && bus.val_o) begin
      exp_t e;
      pulses++;
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_val: val_o=1, expected 0");
      end else begin
        e = q.pop_front();
        if (int'(bus.root_o) != e.root ||
            int'(bus.rem_o) != e.rem ||
            int'(bus.square_o) != e.sq ||
            int'(bus.err_o) != e.err ||
            cyc != e.cyc) begin
          fails++;
          $display({"FAIL result x=%0d: got root=%0d rem=%0d",
                    " sq=%0d err=%0d cyc=%0d, expected root=%0d",
                    " rem=%0d sq=%0d err=%0d cyc=%0d"},
                   e.x, bus.root_o, bus.rem_o, bus.square_o,
                   bus.err_o, cyc, e.root, e.rem, e.sq,
                   e.err, e.cyc);
        end
        if (e.err == 0)
          chk("floor_root", int'(bus.root_o), isqrt(e.x));
      end
    end
  end

  // call at a negedge; returns #1 after the next posedge
  task automatic drive(input bit v, input int x,
                       input int r, input bit use_c,
                       input exp_t ec);
    exp_t e;
    bus.val_i  = v;
    bus.x_i    = 16'(x);
    bus.root_i = 8'(r);
    if (v && bus.rdy_o) begin
      e = use_c ? ec : model(x, r);
      e.x = x;
      e.cyc = cyc + 10;
      q.push_back(e);
      accepts++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy();
    int n = 0;
    @(negedge clk);
    while (!bus.rdy_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rdy_o) chk("rdy_timeout", 0, 1);
  endtask

  task automatic scramble();
    bus.val_i  = 1'b0;
    bus.x_i    = 16'($urandom);
    bus.root_i = 8'($urandom);
  endtask

  task automatic issue_dir(int x, int r, int root,
                           int rem, int sq, int err);
    exp_t ec;
    ec.x = x; ec.root = root; ec.rem = rem;
    ec.sq = sq; ec.err = err; ec.cyc = 0;
    wait_rdy();
    drive(1'b1, x, r, 1'b1, ec);
    scramble();
  endtask

  task automatic issue_rand();
    exp_t ec;
    int r, x;
    ec = '{default: 0};
    r = int'($urandom_range(0, 255));
    if ($urandom_range(0, 3) == 0)
      x = int'($urandom_range(0, 65535));
    else begin
      x = r * r + int'($urandom_range(0, 1200)) - 600;
      if (x < 0) x = 0;
      if (x > 65535) x = 65535;
    end
    wait_rdy();
    drive(1'b1, x, r, 1'b0, ec);
    scramble();
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_val"},  int'(bus.val_o), 0);
    chk({nm, "_outs"},
        int'(bus.root_o) + int'(bus.rem_o) +
        int'(bus.square_o) + int'(bus.err_o), 0);
  endtask

  initial begin
    exp_t ec;
    int n;
    ec = '{default: 0};
    bus.val_i = 1'b0;
    bus.x_i = '0;
    bus.root_i = '0;

    // reset state
    @(negedge clk);
    chk_zero("reset");
    chk("reset_rdy", int'(bus.rdy_o), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_reset", int'(bus.rdy_o), 1);

    // first op with handshake timing
    drive(1'b1, 100, 10, 1'b1,
          '{100, 10, 0, 100, 0, 0});
    scramble();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("rdy_busy", int'(bus.rdy_o), 0);
    end
    @(negedge clk);
    chk("rdy_back", int'(bus.rdy_o), 1);

    issue_dir(99, 10, 9, 18, 100, 0);
    issue_dir(121, 10, 11, 0, 100, 0);
    issue_dir(65535, 255, 255, 510, 65025, 0);
    issue_dir(120, 10, 10, 20, 100, 0);
    issue_dir(0, 0, 0, 0, 0, 0);
    issue_dir(400, 10, 11, 279, 100, 1);
    issue_dir(50, 10, 9, 65505, 100, 1);

    for (int i = 0; i < 30; i++) issue_rand();

    // val_i held high, inputs changing every cycle
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      drive(1'b1, int'($urandom_range(0, 65535)),
            int'($urandom_range(0, 255)), 1'b0, ec);
    end
    scramble();

    // drain before the reset test
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain1", q.size(), 0);

    // reset in the middle of an op
    wait_rdy();
    drive(1'b1, 200, 14, 1'b0, ec);
    scramble();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    accepts -= q.size();
    q.delete();
    @(negedge clk);
    chk_zero("midrst");
    chk("midrst_rdy", int'(bus.rdy_o), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("post_rst_val", int'(bus.val_o), 0);
    end
    chk_zero("post_rst");
    chk("post_rst_rdy", int'(bus.rdy_o), 1);
    issue_dir(99, 10, 9, 18, 100, 0);

    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain2", q.size(), 0);
    chk("pulse_count", pulses, accepts);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
